// File: rtl/regfile_writeback_unit.sv
// Register-file writeback: registered write port fed by the pipeline or by a small late-result FIFO.
// Optional WB_WAW_SQUASH_EN: a pipeline write invalidates queued late results to the same register.
module regfile_writeback_unit #(
  parameter int DATA_BITS    = 32,
  parameter int LINK_REG     = 31,
  parameter int QDEPTH       = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int AB_W        = $clog2(DATA_BITS/8)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [4:0]           rt,
  input  logic [4:0]           rd,
  input  logic                 RegDst,
  input  logic                 Jal,
  input  logic                 MemToReg,
  input  logic                 ExtrSigned,
  input  logic [1:0]           ExtrWord,
  input  logic [1:0]           LHToReg,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] mem_out,
  input  logic [DATA_BITS-1:0] lo,
  input  logic [DATA_BITS-1:0] hi,
  input  logic [DATA_BITS-1:0] pc,
  input  logic [AB_W-1:0]      addr_byte,
  input  logic                 late_valid,
  output logic                 late_ready,
  input  logic [4:0]           late_idx,
  input  logic [DATA_BITS-1:0] late_data,
  output logic                 we,
  output logic [4:0]           W,
  output logic [DATA_BITS-1:0] Din
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [4:0]           q_idx  [QDEPTH];
  logic [DATA_BITS-1:0] q_data [QDEPTH];
  logic [QDEPTH-1:0]    q_live;
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count;
  logic [SW-1:0]        starve_cnt;

  logic full, empty, accept, push, pop;

  assign full       = (count == CW'(QDEPTH));
  assign empty      = (count == '0);
  assign late_ready = !full;
  assign wb_ready   = (starve_cnt != SW'(STARVE_LIMIT));
  assign accept     = wb_valid && wb_ready;
  assign push       = late_valid && !full;
  // Queue is drained only in cycles the pipeline leaves the write port idle.
  assign pop        = !accept && !empty;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Memory extraction: shift the addressed lane down, mask, then sign/zero fill.
  logic [AB_W-1:0]      ext_off;
  logic [DATA_BITS-1:0] ext_mask, shifted, mem_ext;
  logic                 ext_msb, ext_zero;

  always_comb begin
    ext_off  = '0;
    ext_mask = '1;
    ext_zero = 1'b0;
    case (ExtrWord)
      2'd1: begin
        ext_off  = addr_byte;
        ext_mask = DATA_BITS'(8'hFF);
      end
      2'd2: begin
        ext_off  = addr_byte & ~AB_W'(1);
        ext_mask = DATA_BITS'(16'hFFFF);
      end
      2'd3: begin
        ext_off  = addr_byte & ~AB_W'(3);
        ext_mask = DATA_BITS'(32'hFFFF_FFFF);
        ext_zero = (DATA_BITS == 32);
      end
      default: begin
        ext_off  = '0;
        ext_mask = '1;
      end
    endcase
    shifted = mem_out >> {ext_off, 3'b000};
    // Top set bit of the mask marks the sign bit of the extracted field.
    ext_msb = |(shifted & (ext_mask ^ (ext_mask >> 1)));
    mem_ext = (shifted & ext_mask) | ((ExtrSigned && ext_msb) ? ~ext_mask : '0);
    if (ext_zero) mem_ext = '0;
  end

  logic [4:0]           w_sel;
  logic [DATA_BITS-1:0] din_sel;

  always_comb begin
    w_sel   = RegDst ? rd : rt;
    din_sel = alu_out;
    if (Jal) begin
      w_sel   = 5'(LINK_REG);
      din_sel = pc;
    end else if (MemToReg) begin
      din_sel = mem_ext;
    end else if (LHToReg != 2'd0) begin
      case (LHToReg)
        2'd1:    din_sel = lo;
        2'd2:    din_sel = hi;
        default: din_sel = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we  <= 1'b0;
      W   <= '0;
      Din <= '0;
    end else if (accept) begin
      we  <= (w_sel != 5'd0);
      W   <= w_sel;
      Din <= din_sel;
    end else if (pop) begin
      we  <= q_live[rd_ptr] && (q_idx[rd_ptr] != 5'd0);
      W   <= q_idx[rd_ptr];
      Din <= q_data[rd_ptr];
    end else begin
      we  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr]  <= late_idx;
      q_data[wr_ptr] <= late_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_live <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
`ifdef WB_WAW_SQUASH_EN
      if (accept) begin
        for (int i = 0; i < QDEPTH; i++) begin
          if (q_idx[i] == w_sel) q_live[i] <= 1'b0;
        end
      end
`endif
      // A fresh push overrides any squash of a stale slot it reuses.
      if (push) begin
        q_live[wr_ptr] <= 1'b1;
        wr_ptr         <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                starve_cnt <= '0;
    else if (pop || empty)  starve_cnt <= '0;
    else if (accept)        starve_cnt <= starve_cnt + SW'(1);
  end

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Directed bench for regfile_writeback_unit at default parameters (DATA_BITS=32, QDEPTH=2, STARVE_LIMIT=4).
module tb_regfile_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_ready;
  logic [4:0]  rt, rd;
  logic        RegDst, Jal, MemToReg, ExtrSigned;
  logic [1:0]  ExtrWord, LHToReg;
  logic [31:0] alu_out, mem_out, lo, hi, pc;
  logic [1:0]  addr_byte;
  logic        late_valid, late_ready;
  logic [4:0]  late_idx;
  logic [31:0] late_data;
  logic        we;
  logic [4:0]  W;
  logic [31:0] Din;

  int checks = 0;
  int passed = 0;

  regfile_writeback_unit #(.DATA_BITS(32), .LINK_REG(31), .QDEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .rt(rt), .rd(rd), .RegDst(RegDst), .Jal(Jal), .MemToReg(MemToReg),
    .ExtrSigned(ExtrSigned), .ExtrWord(ExtrWord), .LHToReg(LHToReg),
    .alu_out(alu_out), .mem_out(mem_out), .lo(lo), .hi(hi), .pc(pc),
    .addr_byte(addr_byte), .late_valid(late_valid), .late_ready(late_ready),
    .late_idx(late_idx), .late_data(late_data), .we(we), .W(W), .Din(Din)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    wb_valid = 0; rt = 0; rd = 0; RegDst = 0; Jal = 0; MemToReg = 0;
    ExtrSigned = 0; ExtrWord = 0; LHToReg = 0; alu_out = 0; mem_out = 0;
    lo = 0; hi = 0; pc = 0; addr_byte = 0; late_valid = 0; late_idx = 0; late_data = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1;
    step(); step();
    checks++; if (we !== 1'b0) $display("FAIL reset_we got=%b exp=0", we); else passed++;
    checks++; if (W !== 5'd0) $display("FAIL reset_W got=%0d exp=0", W); else passed++;
    checks++; if (Din !== 32'd0) $display("FAIL reset_Din got=%h exp=0", Din); else passed++;
    rst = 0;
    step();
    checks++; if (wb_ready !== 1'b1) $display("FAIL reset_wb_ready got=%b exp=1", wb_ready); else passed++;
    checks++; if (late_ready !== 1'b1) $display("FAIL reset_late_ready got=%b exp=1", late_ready); else passed++;
    checks++; if (we !== 1'b0) $display("FAIL reset_we_after got=%b exp=0", we); else passed++;
  endtask

  typedef struct {
    logic        m2r;
    logic [1:0]  lh;
    logic [1:0]  ew;
    logic        sgn;
    logic [1:0]  ab;
    logic [31:0] exp;
  } vec_t;

  task automatic test_din_select;
    vec_t v[10];
    v[0] = '{1'b1, 2'd1, 2'd1, 1'b1, 2'd2, 32'hFFFF_FFA4};
    v[1] = '{1'b1, 2'd0, 2'd1, 1'b0, 2'd2, 32'h0000_00A4};
    v[2] = '{1'b1, 2'd0, 2'd2, 1'b0, 2'd3, 32'h0000_12A4};
    v[3] = '{1'b1, 2'd0, 2'd2, 1'b1, 2'd1, 32'h0000_5678};
    v[4] = '{1'b1, 2'd0, 2'd3, 1'b1, 2'd0, 32'h0000_0000};
    v[5] = '{1'b1, 2'd0, 2'd0, 1'b1, 2'd3, 32'h12A4_5678};
    v[6] = '{1'b0, 2'd1, 2'd0, 1'b0, 2'd0, 32'h0000_1111};
    v[7] = '{1'b0, 2'd2, 2'd0, 1'b0, 2'd0, 32'h0000_2222};
    v[8] = '{1'b0, 2'd3, 2'd0, 1'b0, 2'd0, 32'h0000_0000};
    v[9] = '{1'b0, 2'd0, 2'd1, 1'b1, 2'd2, 32'h0000_ABCD};
    idle_inputs();
    mem_out = 32'h12A4_5678; lo = 32'h1111; hi = 32'h2222; alu_out = 32'hABCD;
    rt = 5'd3; rd = 5'd12;
    for (int i = 0; i < 10; i++) begin
      wb_valid = 1; MemToReg = v[i].m2r; LHToReg = v[i].lh; ExtrWord = v[i].ew;
      ExtrSigned = v[i].sgn; addr_byte = v[i].ab;
      step();
      checks++; if (we !== 1'b1) $display("FAIL din_we[%0d] got=%b exp=1", i, we); else passed++;
      checks++; if (Din !== v[i].exp) $display("FAIL din_val[%0d] got=%h exp=%h", i, Din, v[i].exp); else passed++;
      checks++; if (W !== 5'd3) $display("FAIL din_W[%0d] got=%0d exp=3", i, W); else passed++;
    end
    RegDst = 1; MemToReg = 0; LHToReg = 0;
    step();
    checks++; if (W !== 5'd12) $display("FAIL regdst_W got=%0d exp=12", W); else passed++;
    idle_inputs();
  endtask

  task automatic test_jal_and_r0;
    idle_inputs();
    wb_valid = 1; Jal = 1; pc = 32'h0040_0010; rt = 5'd4; alu_out = 32'h55;
    step();
    checks++; if (we !== 1'b1) $display("FAIL jal_we got=%b exp=1", we); else passed++;
    checks++; if (W !== 5'd31) $display("FAIL jal_W got=%0d exp=31", W); else passed++;
    checks++; if (Din !== 32'h0040_0010) $display("FAIL jal_Din got=%h exp=00400010", Din); else passed++;
    Jal = 0; rt = 5'd0; alu_out = 32'h77;
    step();
    checks++; if (we !== 1'b0) $display("FAIL r0_we got=%b exp=0", we); else passed++;
    checks++; if (W !== 5'd0) $display("FAIL r0_W got=%0d exp=0", W); else passed++;
    wb_valid = 0; alu_out = 32'h99;
    step();
    checks++; if (we !== 1'b0) $display("FAIL hold_we got=%b exp=0", we); else passed++;
    checks++; if (Din !== 32'h77) $display("FAIL hold_Din got=%h exp=77", Din); else passed++;
    idle_inputs();
  endtask

  task automatic test_late;
    idle_inputs();
    late_valid = 1; late_idx = 5'd5; late_data = 32'hCAFE;
    step();
    late_valid = 0;
    checks++; if (we !== 1'b0) $display("FAIL late_queued_we got=%b exp=0", we); else passed++;
    step();
    checks++; if (we !== 1'b1) $display("FAIL late_pop_we got=%b exp=1", we); else passed++;
    checks++; if (W !== 5'd5) $display("FAIL late_pop_W got=%0d exp=5", W); else passed++;
    checks++; if (Din !== 32'hCAFE) $display("FAIL late_pop_Din got=%h exp=cafe", Din); else passed++;
    step();
    checks++; if (we !== 1'b0) $display("FAIL late_drained_we got=%b exp=0", we); else passed++;
  endtask

  task automatic test_starve;
    idle_inputs();
    wb_valid = 1; rt = 5'd2; alu_out = 32'h100;
    late_valid = 1; late_idx = 5'd7; late_data = 32'h77;
    step();
    late_valid = 0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (wb_ready !== 1'b1) $display("FAIL starve_ready[%0d] got=%b exp=1", k, wb_ready); else passed++;
      step();
      checks++; if (we !== 1'b1 || W !== 5'd2) $display("FAIL starve_accept[%0d] got we=%b W=%0d exp we=1 W=2", k, we, W); else passed++;
    end
    checks++; if (wb_ready !== 1'b0) $display("FAIL starve_block got=%b exp=0", wb_ready); else passed++;
    step();
    checks++; if (we !== 1'b1 || W !== 5'd7 || Din !== 32'h77) $display("FAIL starve_pop got we=%b W=%0d Din=%h exp we=1 W=7 Din=77", we, W, Din); else passed++;
    checks++; if (wb_ready !== 1'b1) $display("FAIL starve_release got=%b exp=1", wb_ready); else passed++;
    wb_valid = 0;
    step();
  endtask

  task automatic test_full;
    idle_inputs();
    wb_valid = 1; rt = 5'd4; alu_out = 32'h40;
    late_valid = 1; late_idx = 5'd9; late_data = 32'h99;
    step();
    checks++; if (late_ready !== 1'b1) $display("FAIL full_ready1 got=%b exp=1", late_ready); else passed++;
    late_idx = 5'd10; late_data = 32'hAA;
    step();
    checks++; if (late_ready !== 1'b0) $display("FAIL full_ready2 got=%b exp=0", late_ready); else passed++;
    late_idx = 5'd11; late_data = 32'hBB;
    step();
    checks++; if (late_ready !== 1'b0) $display("FAIL full_held got=%b exp=0", late_ready); else passed++;
    wb_valid = 0; late_valid = 0;
    step();
    checks++; if (we !== 1'b1 || W !== 5'd9 || Din !== 32'h99) $display("FAIL full_pop1 got we=%b W=%0d Din=%h exp we=1 W=9 Din=99", we, W, Din); else passed++;
    checks++; if (late_ready !== 1'b1) $display("FAIL full_ready3 got=%b exp=1", late_ready); else passed++;
    step();
    checks++; if (we !== 1'b1 || W !== 5'd10 || Din !== 32'hAA) $display("FAIL full_pop2 got we=%b W=%0d Din=%h exp we=1 W=10 Din=aa", we, W, Din); else passed++;
    step();
    checks++; if (we !== 1'b0) $display("FAIL full_empty got=%b exp=0", we); else passed++;
  endtask

  task automatic test_waw;
    idle_inputs();
    wb_valid = 1; RegDst = 1; rd = 5'd6; alu_out = 32'h60;
    late_valid = 1; late_idx = 5'd5; late_data = 32'h55;
    step();
    late_valid = 0; rd = 5'd5; alu_out = 32'h65;
    step();
    checks++; if (we !== 1'b1 || W !== 5'd5 || Din !== 32'h65) $display("FAIL waw_pipe got we=%b W=%0d Din=%h exp we=1 W=5 Din=65", we, W, Din); else passed++;
    wb_valid = 0;
    step();
`ifdef WB_WAW_SQUASH_EN
    checks++; if (we !== 1'b0) $display("FAIL waw_squash got=%b exp=0", we); else passed++;
`else
    checks++; if (we !== 1'b1 || W !== 5'd5 || Din !== 32'h55) $display("FAIL waw_overwrite got we=%b W=%0d Din=%h exp we=1 W=5 Din=55", we, W, Din); else passed++;
`endif
    step();
    checks++; if (we !== 1'b0) $display("FAIL waw_drained got=%b exp=0", we); else passed++;
  endtask

  task automatic test_reset_mid;
    idle_inputs();
    wb_valid = 1; rt = 5'd8; alu_out = 32'h80;
    late_valid = 1; late_idx = 5'd12; late_data = 32'hC;
    step();
    late_idx = 5'd13; late_data = 32'hD;
    step();
    late_valid = 0;
    checks++; if (we !== 1'b1) $display("FAIL rstmid_pre got=%b exp=1", we); else passed++;
    rst = 1;
    #1;
    checks++; if (we !== 1'b0 || W !== 5'd0 || Din !== 32'd0) $display("FAIL rstmid_async got we=%b W=%0d Din=%h exp 0/0/0", we, W, Din); else passed++;
    wb_valid = 0;
    step();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (we !== 1'b0) $display("FAIL rstmid_nowrite[%0d] got=%b exp=0", k, we); else passed++;
    end
    checks++; if (late_ready !== 1'b1 || wb_ready !== 1'b1) $display("FAIL rstmid_ready got late=%b wb=%b exp 1/1", late_ready, wb_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_din_select();
    test_jal_and_r0();
    test_late();
    test_starve();
    test_full();
    test_waw();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
